// File: rtl/soc_arb_pkg.sv
// Shared types and limits for the instruction/data memory arbiter.
package soc_arb_pkg;

  localparam int unsigned ARB_MAX_OUTSTANDING_LIMIT = 4;
  localparam int unsigned ARB_ADDR_W                = 32;
  localparam int unsigned ARB_DATA_W                = 32;
  localparam int unsigned ARB_BE_W                  = 4;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } arb_src_e;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_INST,
    HOLD_DATA
  } arb_state_e;

  // Request attributes presented to the shared memory port
  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/CORE_DATA_INF.sv
// Core data bus (OBI-style request/grant/rvalid), also used for the shared memory port.
interface CORE_DATA_INF;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport Slave  (input data_req, data_we, data_be, data_addr, data_wdata,
                  output data_gnt, data_rvalid, data_rdata);
  modport Master (output data_req, data_we, data_be, data_addr, data_wdata,
                  input data_gnt, data_rvalid, data_rdata);
endinterface

// File: rtl/CORE_INST_INF.sv
// Core instruction fetch bus (OBI-style request/grant/rvalid).
interface CORE_INST_INF;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;

  modport Slave  (input instr_req, instr_addr, output instr_gnt, instr_rvalid, instr_rdata);
  modport Master (output instr_req, instr_addr, input instr_gnt, instr_rvalid, instr_rdata);
endinterface

// File: rtl/cv32e_arb_id_fifo.sv
// In-order FIFO of source IDs for granted transactions awaiting rvalid.
module cv32e_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset: occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/cv32e_inst_data_arbiter.sv
// Arbitrates the core instruction and data ports onto one memory port with
// zero-latency grant/response paths and in-order response routing.
module cv32e_inst_data_arbiter
  import soc_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_PRIORITY   = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  CORE_INST_INF.Slave  inst_slave_inf,
  CORE_DATA_INF.Slave  data_slave_inf,
  CORE_DATA_INF.Master mem_master_inf,
  output logic         err_o
);

  localparam int unsigned DEPTH =
      (MAX_OUTSTANDING > ARB_MAX_OUTSTANDING_LIMIT) ? ARB_MAX_OUTSTANDING_LIMIT :
      (MAX_OUTSTANDING == 0) ? 1 : MAX_OUTSTANDING;

  arb_state_e state_q, state_d;
  arb_src_e   last_q, sel, head_src;
  arb_req_t   inst_pl, data_pl, mem_pl;
  logic       ireq, dreq, sel_req, mem_valid, handshake;
  logic       fifo_full, fifo_empty, resp_ok;
  logic [0:0] head_bit;
  logic       err_q;

  assign ireq = inst_slave_inf.instr_req;
  assign dreq = data_slave_inf.data_req;

  // Selection and next state; HOLD states lock the choice until granted
  always_comb begin
    state_d = state_q;
    sel     = SRC_INST;
    case (state_q)
      HOLD_INST: sel = SRC_INST;
      HOLD_DATA: sel = SRC_DATA;
      default: begin
        if (ireq && dreq)
          sel = (DATA_PRIORITY != 0 || last_q == SRC_INST) ? SRC_DATA : SRC_INST;
        else if (dreq)
          sel = SRC_DATA;
      end
    endcase
    sel_req = (sel == SRC_DATA) ? dreq : ireq;
    if (!fifo_full && sel_req)
      state_d = mem_master_inf.data_gnt ? IDLE :
                (sel == SRC_DATA) ? HOLD_DATA : HOLD_INST;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= SRC_INST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) last_q <= sel;
      if (mem_master_inf.data_rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign inst_pl = '{we: 1'b0, be: 4'hF, addr: inst_slave_inf.instr_addr, wdata: '0};
  assign data_pl = '{we: data_slave_inf.data_we, be: data_slave_inf.data_be,
                     addr: data_slave_inf.data_addr, wdata: data_slave_inf.data_wdata};
  assign mem_pl  = (sel == SRC_DATA) ? data_pl : inst_pl;

  assign mem_valid = rst_ni && !fifo_full && sel_req;
  assign handshake = mem_valid && mem_master_inf.data_gnt;

  assign mem_master_inf.data_req   = mem_valid;
  assign mem_master_inf.data_we    = mem_pl.we;
  assign mem_master_inf.data_be    = mem_pl.be;
  assign mem_master_inf.data_addr  = mem_pl.addr;
  assign mem_master_inf.data_wdata = mem_pl.wdata;

  assign inst_slave_inf.instr_gnt = handshake && (sel == SRC_INST);
  assign data_slave_inf.data_gnt  = handshake && (sel == SRC_DATA);

  cv32e_arb_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .din    (sel),
    .pop    (resp_ok),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head_bit)
  );

  // Responses follow grant order; an rvalid with nothing outstanding is dropped
  assign head_src = arb_src_e'(head_bit);
  assign resp_ok  = rst_ni && mem_master_inf.data_rvalid && !fifo_empty;

  assign inst_slave_inf.instr_rvalid = resp_ok && (head_src == SRC_INST);
  assign data_slave_inf.data_rvalid  = resp_ok && (head_src == SRC_DATA);
  assign inst_slave_inf.instr_rdata  = mem_master_inf.data_rdata;
  assign data_slave_inf.data_rdata   = mem_master_inf.data_rdata;

  assign err_o = err_q;

endmodule

// File: tb/tb_cv32e_inst_data_arbiter.sv
// Bench for cv32e_inst_data_arbiter: two instances (priority / round-robin,
// depth 2 / 3) checked against a queue-based transaction model.
module tb_cv32e_inst_data_arbiter;

  localparam int NDUT = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic        i_req [NDUT];
  logic [31:0] i_addr [NDUT];
  logic        d_req [NDUT];
  logic        d_we [NDUT];
  logic [3:0]  d_be [NDUT];
  logic [31:0] d_addr [NDUT];
  logic [31:0] d_wdata [NDUT];
  logic        m_gnt [NDUT];
  logic        m_rvalid [NDUT];
  logic [31:0] m_rdata [NDUT];

  logic        i_gnt [NDUT];
  logic        i_rvalid [NDUT];
  logic [31:0] i_rdata [NDUT];
  logic        d_gnt [NDUT];
  logic        d_rvalid [NDUT];
  logic [31:0] d_rdata [NDUT];
  logic        m_req [NDUT];
  logic        m_we [NDUT];
  logic [3:0]  m_be [NDUT];
  logic [31:0] m_addr [NDUT];
  logic [31:0] m_wdata [NDUT];
  logic        err [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    CORE_INST_INF iif ();
    CORE_DATA_INF dif ();
    CORE_DATA_INF mif ();

    assign iif.instr_req  = i_req[g];
    assign iif.instr_addr = i_addr[g];
    assign dif.data_req   = d_req[g];
    assign dif.data_we    = d_we[g];
    assign dif.data_be    = d_be[g];
    assign dif.data_addr  = d_addr[g];
    assign dif.data_wdata = d_wdata[g];
    assign mif.data_gnt    = m_gnt[g];
    assign mif.data_rvalid = m_rvalid[g];
    assign mif.data_rdata  = m_rdata[g];

    assign i_gnt[g]    = iif.instr_gnt;
    assign i_rvalid[g] = iif.instr_rvalid;
    assign i_rdata[g]  = iif.instr_rdata;
    assign d_gnt[g]    = dif.data_gnt;
    assign d_rvalid[g] = dif.data_rvalid;
    assign d_rdata[g]  = dif.data_rdata;
    assign m_req[g]    = mif.data_req;
    assign m_we[g]     = mif.data_we;
    assign m_be[g]     = mif.data_be;
    assign m_addr[g]   = mif.data_addr;
    assign m_wdata[g]  = mif.data_wdata;

    cv32e_inst_data_arbiter #(
      .MAX_OUTSTANDING ((g == 0) ? 2 : 3),
      .DATA_PRIORITY   ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .inst_slave_inf (iif),
      .data_slave_inf (dif),
      .mem_master_inf (mif),
      .err_o          (err[g])
    );
  end

  // Transaction model: outstanding source IDs (0 = inst, 1 = data) in grant order
  int unsigned qcnt [NDUT];
  logic        qsrc [NDUT][4];
  logic        hold_v [NDUT];
  logic        hold_s [NDUT];
  logic        last_s [NDUT];
  logic        err_m [NDUT];
  logic        i_pend [NDUT];
  logic        d_pend [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int unsigned max_out(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic data_prio(input int k);
    return (k == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%h expected=%h @%0t", tag, obs, exp, $time);
  endtask

  task automatic model_cycle(input int k);
    logic  ir, dr, src, sreq, mreq, pop_ok;
    string p;
    p  = $sformatf("dut%0d", k);
    ir = i_req[k];
    dr = d_req[k];
    if (!rst_n) begin
      check({p, ".rst_mreq"}, 32'(m_req[k]), 0);
      check({p, ".rst_gnt"}, {30'd0, i_gnt[k], d_gnt[k]}, 0);
      check({p, ".rst_rvalid"}, {30'd0, i_rvalid[k], d_rvalid[k]}, 0);
      check({p, ".rst_err"}, 32'(err[k]), 0);
      qcnt[k] = 0; hold_v[k] = 0; last_s[k] = 0; err_m[k] = 0;
      i_pend[k] = 0; d_pend[k] = 0;
      return;
    end
    if (hold_v[k])      src = hold_s[k];
    else if (ir && dr)  src = data_prio(k) ? 1'b1 : !last_s[k];
    else                src = dr;
    sreq = src ? dr : ir;
    mreq = sreq && (qcnt[k] < max_out(k));
    check({p, ".mreq"}, 32'(m_req[k]), 32'(mreq));
    check({p, ".igant"}, 32'(i_gnt[k]), 32'(mreq && !src && m_gnt[k]));
    check({p, ".dgnt"}, 32'(d_gnt[k]), 32'(mreq && src && m_gnt[k]));
    if (mreq) begin
      check({p, ".maddr"}, m_addr[k], src ? d_addr[k] : i_addr[k]);
      check({p, ".mwe"}, 32'(m_we[k]), src ? 32'(d_we[k]) : 0);
      check({p, ".mbe"}, 32'(m_be[k]), src ? 32'(d_be[k]) : 32'hF);
      check({p, ".mwdata"}, m_wdata[k], src ? d_wdata[k] : 0);
    end
    pop_ok = m_rvalid[k] && (qcnt[k] > 0);
    check({p, ".irvalid"}, 32'(i_rvalid[k]), 32'(pop_ok && !qsrc[k][0]));
    check({p, ".drvalid"}, 32'(d_rvalid[k]), 32'(pop_ok && qsrc[k][0]));
    check({p, ".irdata"}, i_rdata[k], m_rdata[k]);
    check({p, ".drdata"}, d_rdata[k], m_rdata[k]);
    check({p, ".err"}, 32'(err[k]), 32'(err_m[k]));
    // advance to the next clock edge
    if (m_rvalid[k]) begin
      if (qcnt[k] > 0) begin
        for (int j = 0; j < 3; j++) qsrc[k][j] = qsrc[k][j+1];
        qcnt[k]--;
      end else begin
        err_m[k] = 1;
      end
    end
    if (mreq && m_gnt[k]) begin
      qsrc[k][qcnt[k]] = src;
      qcnt[k]++;
      last_s[k] = src;
      hold_v[k] = 0;
    end else if (mreq) begin
      hold_v[k] = 1;
      hold_s[k] = src;
    end
    i_pend[k] = ir && !(mreq && !src && m_gnt[k]);
    d_pend[k] = dr && !(mreq && src && m_gnt[k]);
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) model_cycle(k);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < NDUT; k++) begin
      i_req[k] = 0; i_addr[k] = 0;
      d_req[k] = 0; d_we[k] = 0; d_be[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
      m_gnt[k] = 0; m_rvalid[k] = 0; m_rdata[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int k = 0; k < NDUT; k++) begin
      i_req[k] = 1; d_req[k] = 1; m_gnt[k] = 1; m_rvalid[k] = 1;
    end
    step();
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic drain();
    for (int n = 0; n < 6; n++) begin
      idle_inputs();
      for (int k = 0; k < NDUT; k++) m_rvalid[k] = (qcnt[k] > 0);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    step();

    // Single instruction fetch, same-cycle grant, response next cycle
    do_reset();
    for (int k = 0; k < NDUT; k++) begin
      i_req[k] = 1; i_addr[k] = 32'h0000_0100; m_gnt[k] = 1;
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("fetch.igant", 32'(i_gnt[k]), 1);
      check("fetch.dgnt", 32'(d_gnt[k]), 0);
      check("fetch.maddr", m_addr[k], 32'h0000_0100);
      check("fetch.mwe", 32'(m_we[k]), 0);
      check("fetch.mbe", 32'(m_be[k]), 32'hF);
    end
    step();
    idle_inputs();
    for (int k = 0; k < NDUT; k++) begin
      m_rvalid[k] = 1; m_rdata[k] = 32'hDEAD_BEEF;
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("fetch.irvalid", 32'(i_rvalid[k]), 1);
      check("fetch.irdata", i_rdata[k], 32'hDEAD_BEEF);
      check("fetch.drvalid", 32'(d_rvalid[k]), 0);
    end
    step();
    idle_inputs();

    // Simultaneous requests: data first, responses routed in grant order
    do_reset();
    for (int k = 0; k < NDUT; k++) begin
      i_req[k] = 1; i_addr[k] = 32'h200;
      d_req[k] = 1; d_addr[k] = 32'h300; d_we[k] = 1; d_be[k] = 4'h3; d_wdata[k] = 32'h1234;
      m_gnt[k] = 1;
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("tie.dgnt", 32'(d_gnt[k]), 1);
      check("tie.igant", 32'(i_gnt[k]), 0);
      check("tie.maddr", m_addr[k], 32'h300);
    end
    step();
    for (int k = 0; k < NDUT; k++) begin
      d_req[k] = 0; m_rvalid[k] = 1; m_rdata[k] = 32'hAAAA_0001;
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("tie2.igant", 32'(i_gnt[k]), 1);
      check("tie2.drvalid", 32'(d_rvalid[k]), 1);
      check("tie2.irvalid", 32'(i_rvalid[k]), 0);
    end
    step();
    for (int k = 0; k < NDUT; k++) begin
      i_req[k] = 0; m_rvalid[k] = 1; m_rdata[k] = 32'hBBBB_0002;
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("tie3.irvalid", 32'(i_rvalid[k]), 1);
      check("tie3.drvalid", 32'(d_rvalid[k]), 0);
    end
    step();
    idle_inputs();

    // Continuous contention: round-robin alternates, fixed priority keeps data
    do_reset();
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        i_req[k] = 1; i_addr[k] = 32'h1000 + 32'(n);
        d_req[k] = 1; d_addr[k] = 32'h2000 + 32'(n);
        m_gnt[k] = 1; m_rvalid[k] = (qcnt[k] > 0); m_rdata[k] = 32'(n);
      end
      #1;
      check($sformatf("rr%0d.dgnt", n), 32'(d_gnt[1]), 32'(n % 2 == 0));
      check($sformatf("rr%0d.igant", n), 32'(i_gnt[1]), 32'(n % 2 == 1));
      check($sformatf("prio%0d.dgnt", n), 32'(d_gnt[0]), 1);
      step();
    end
    drain();

    // Withheld grant: held instruction is not preempted by a later data request
    do_reset();
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        i_req[k] = (n < 4); i_addr[k] = 32'h400;
        d_req[k] = (n >= 1); d_addr[k] = 32'h500;
        m_gnt[k] = (n >= 3);
        m_rvalid[k] = (qcnt[k] > 0);
      end
      #1;
      for (int k = 0; k < NDUT; k++) begin
        if (n < 3) begin
          check("hold.dgnt", 32'(d_gnt[k]), 0);
          check("hold.maddr", m_addr[k], 32'h400);
        end else if (n == 3) begin
          check("hold.igant", 32'(i_gnt[k]), 1);
          check("hold.dgnt_wait", 32'(d_gnt[k]), 0);
        end else begin
          check("hold.dgnt_next", 32'(d_gnt[k]), 1);
          check("hold.maddr_next", m_addr[k], 32'h500);
        end
      end
      step();
    end
    drain();

    // Outstanding limit on the depth-2 instance
    do_reset();
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        i_req[k] = 1; i_addr[k] = 32'h600 + 32'(n * 4);
        m_gnt[k] = 1; m_rvalid[k] = (n == 3) && (qcnt[k] > 0);
      end
      #1;
      if (n < 2)       check("lim.igant", 32'(i_gnt[0]), 1);
      else if (n < 4)  check("lim.mreq_blocked", 32'(m_req[0]), 0);
      else             check("lim.mreq_resume", 32'(m_req[0]), 1);
      step();
    end
    drain();

    // Spurious response sets sticky err, cleared only by reset
    do_reset();
    for (int k = 0; k < NDUT; k++) m_rvalid[k] = 1;
    #1;
    for (int k = 0; k < NDUT; k++)
      check("spur.rvalid", {30'd0, i_rvalid[k], d_rvalid[k]}, 0);
    step();
    idle_inputs();
    for (int n = 0; n < 2; n++) begin
      #1;
      for (int k = 0; k < NDUT; k++) check("spur.err", 32'(err[k]), 1);
      step();
    end
    rst_n = 0;
    #1;
    for (int k = 0; k < NDUT; k++) check("spur.err_rst", 32'(err[k]), 0);
    step();
    rst_n = 1;
    step();

    // Randomized traffic with OBI-stable masters
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < NDUT; k++) begin
        if (!i_pend[k]) begin
          i_req[k]  = 1'($urandom_range(0, 1));
          i_addr[k] = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_pend[k]) begin
          d_req[k]   = 1'($urandom_range(0, 1));
          d_we[k]    = 1'($urandom_range(0, 1));
          d_be[k]    = 4'($urandom_range(0, 15));
          d_addr[k]  = $urandom & 32'hFFFF_FFFC;
          d_wdata[k] = $urandom;
        end
        m_gnt[k]    = ($urandom_range(0, 3) != 0);
        m_rvalid[k] = (qcnt[k] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
        m_rdata[k]  = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
